// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-service path.
//   clogb2        : ceiling log2, usable in localparam expressions
//   BURST_INCR    : AXI4 INCR burst encoding
//   RESP_OKAY     : AXI4 OKAY response encoding
//   fetch_state_e : cache_line_fetcher FSM states
package cache_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

  // Smallest r with (1 << r) >= value; returns 0 for value <= 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_line_fetcher_if.sv
// Bundle of every handshake/bus signal of cache_line_fetcher.
//   req_*    : miss request stream (tag in)
//   line_*   : assembled line stream (line out, tuser = bus error)
//   m_axi_ar*: AXI4 read address channel
//   m_axi_r* : AXI4 read data channel
// Modports: master = the fetcher itself, slave = cache way + AXI memory side.
//
// Handshake rule for every stream/channel here: a transfer happens on a
// rising clk edge where valid and ready are both 1; once valid is raised it
// stays high and its payload stays stable until that transfer.
interface cache_line_fetcher_if #(
  parameter int TAGS_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
);
  logic                  req_tvalid;
  logic                  req_tready;
  logic [TAGS_WIDTH-1:0] req_tdata;

  logic                  line_tvalid;
  logic                  line_tready;
  logic [LINE_WIDTH-1:0] line_tdata;
  logic                  line_tuser;

  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  req_tvalid, req_tdata, line_tready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_tready, line_tvalid, line_tdata, line_tuser,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_rready
  );

  modport slave (
    output req_tvalid, req_tdata, line_tready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  req_tready, line_tvalid, line_tdata, line_tuser,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_line_assembler.sv
// Collects the beats of one AXI read burst into a cache line.
//   clk, rstn : clock, asynchronous active-high reset
//   clear     : start of a new fill (zero beat counter and error flag)
//   beat      : rvalid & rready this cycle
//   rdata/rresp/rlast : beat payload
//   line      : assembled line, beat n at [n*DATA_WIDTH +: DATA_WIDTH]
//   done      : this beat ends the burst (rlast or final beat index)
//   err       : sticky error flag including the current beat
module axi_line_assembler
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  beat,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  done,
  output logic                  err
);
  localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int CW    = (BEATS > 1) ? clogb2(BEATS) : 1;

  logic [CW-1:0] cnt;
  logic          err_q;
  logic          last_idx;
  logic          beat_err;

  always_comb begin
    last_idx = (cnt == CW'(BEATS - 1));
    // rlast must coincide exactly with the final beat index.
    beat_err = (rresp != RESP_OKAY) || (rlast != last_idx);
    done     = beat && (rlast || last_idx);
    err      = err_q || (beat && beat_err);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (beat) begin
      cnt   <= done ? '0 : cnt + 1'b1;
      err_q <= err;
    end
  end

  // Line storage is deliberately not reset: its contents only matter once
  // a full fill has landed.
  always_ff @(posedge clk) begin
    if (beat) line[int'(cnt) * DATA_WIDTH +: DATA_WIDTH] <= rdata;
  end

endmodule

// File: rtl/cache_line_fetcher.sv
// Miss-service stage: takes one line tag, issues one AXI4 INCR read burst of
// LINE_WIDTH/DATA_WIDTH beats, and returns the assembled line. One miss is
// outstanding at a time.
//   clk, rstn : clock, asynchronous active-high reset
//   bus       : cache_line_fetcher_if.master (request, line, AXI AR and R)
//   dbg_state : current FSM state
module cache_line_fetcher
  import cache_pkg::*;
#(
  parameter int                    TAGS_WIDTH = 48,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    LINE_WIDTH = 512,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  cache_line_fetcher_if.master       bus,
  output fetch_state_e               dbg_state
);
  localparam int BEATS      = LINE_WIDTH / DATA_WIDTH;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int OFFS       = clogb2(LINE_BYTES);

  fetch_state_e          state;
  logic [TAGS_WIDTH-1:0] req_tag;
  logic                  req_fire;
  logic                  beat;
  logic                  fill_done;
  logic                  fill_err;
  logic [LINE_WIDTH-1:0] line_q;

  assign req_tag   = bus.req_tdata;
  assign req_fire  = bus.req_tvalid && bus.req_tready;
  assign beat      = bus.m_axi_rvalid && bus.m_axi_rready;
  assign dbg_state = state;

  assign bus.m_axi_arlen   = 8'(BEATS - 1);
  assign bus.m_axi_arsize  = 3'(clogb2(DATA_WIDTH / 8));
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.line_tdata    = line_q;

  axi_line_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_asm (
    .clk   (clk),
    .rstn  (rstn),
    .clear (req_fire),
    .beat  (beat),
    .rdata (bus.m_axi_rdata),
    .rresp (bus.m_axi_rresp),
    .rlast (bus.m_axi_rlast),
    .line  (line_q),
    .done  (fill_done),
    .err   (fill_err)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state             <= ST_IDLE;
      bus.req_tready    <= 1'b0;
      bus.m_axi_arvalid <= 1'b0;
      bus.m_axi_rready  <= 1'b0;
      bus.line_tvalid   <= 1'b0;
      bus.line_tuser    <= 1'b0;
      bus.m_axi_araddr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.req_tready <= 1'b1;
          if (req_fire) begin
            bus.req_tready    <= 1'b0;
            // Sum wraps modulo 2^ADDR_WIDTH.
            bus.m_axi_araddr  <= BASE_ADDR + (ADDR_WIDTH'(req_tag) << OFFS);
            bus.m_axi_arvalid <= 1'b1;
            state             <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.m_axi_arready) begin
            bus.m_axi_arvalid <= 1'b0;
            bus.m_axi_rready  <= 1'b1;
            state             <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (fill_done) begin
            bus.m_axi_rready <= 1'b0;
            bus.line_tvalid  <= 1'b1;
            bus.line_tuser   <= fill_err;
            state            <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.line_tready) begin
            bus.line_tvalid <= 1'b0;
            bus.req_tready  <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
